mda_text_pixel_pipe: RTL and testbench

MDA_TEXT_PIXEL_PIPE -- requirements
Module: mda_text_pixel_pipe

---
 rtl/mda_text_pixel_pipe_pkg.sv | 31 +++
 rtl/mda_attr_decode.sv | 35 +++
 rtl/mda_text_pixel_pipe.sv | 144 ++++++++++++++
 tb/tb_mda_text_pixel_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mda_text_pixel_pipe_pkg.sv
// Shared video definitions for the MDA text pixel pipe.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mda_text_pixel_pipe_pkg;

    localparam int CHAR_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CHAR = 3'd1,
        ST_RD_ATTR = 3'd2,
        ST_RD_FONT = 3'd3,
        ST_HOLD    = 3'd4
    } fetch_state_e;

    localparam logic [3:0] IRGB_BLACK     = 4'h0;
    localparam logic [3:0] IRGB_INTENSITY = 4'h8;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic cursor;
    } timing_t;

    typedef struct packed {
        logic [7:0] attr;
        timing_t    tim;
    } cell_meta_t;

endpackage

// File: rtl/mda_attr_decode.sv
// Resolves attribute byte, glyph bit, cursor and blink into one IRGB pixel.
// Latency: combinational.
// Backpressure: none.
module mda_attr_decode
    import mda_text_pixel_pipe_pkg::*;
(
    input  logic [7:0] attr,
    input  logic       glyph_bit,
    input  logic       cursor,
    input  logic       blink,
    input  logic       blink_en,
    input  logic       de,
    output logic [3:0] pixel
);

    logic [3:0] fg;
    logic [3:0] bg;

    always_comb begin
        bg = {1'b0, attr[6:4]} | ((attr[7] && !blink_en) ? IRGB_INTENSITY : IRGB_BLACK);
        fg = attr[3:0];
        // Blinking characters collapse to background during the off phase.
        if (blink_en && attr[7] && !blink) begin
            fg = bg;
        end
        if (!de) begin
            pixel = IRGB_BLACK;
        end else if (cursor || glyph_bit) begin
            pixel = fg;
        end else begin
            pixel = bg;
        end
    end

endmodule

// File: rtl/mda_text_pixel_pipe.sv
// MDA text pipe: fetches char/attr/glyph per cell and shifts out IRGB pixels.
// Latency: one character period (cell sampled at divclk N is shown after divclk N+1).
// Backpressure: none; free-running, a divclk mid-fetch restarts the fetch.
module mda_text_pixel_pipe
    import mda_text_pixel_pipe_pkg::*;
#(
    parameter int BLINK_BIT = 4,
    parameter int CHAR_W    = CHAR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        divclk,
    input  logic [13:0] mem_addr,
    input  logic [4:0]  row_addr,
    input  logic        display_enable,
    input  logic        cursor,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blink_en,
    output logic [14:0] vram_addr,
    output logic        vram_rd,
    input  logic [7:0]  vram_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  pixel,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o
);

    fetch_state_e      state, state_nx;
    logic [13:0]       addr_q;
    logic [2:0]        row_q;
    logic [7:0]        char_q;
    logic [7:0]        attr_stg;
    logic [7:0]        glyph_stg;
    logic [7:0]        glyph_now;
    logic              font_pend;
    timing_t           tim_lat;
    cell_meta_t        meta_sh;
    logic [CHAR_W-1:0] shift_q;
    logic [4:0]        frame_cnt;
    logic              vsync_q;
    logic              unused_row_bits;

    assign unused_row_bits = ^row_addr[4:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        vram_rd   = 1'b0;
        vram_addr = '0;
        font_addr = '0;
        case (state)
            ST_IDLE: state_nx = ST_IDLE;
            ST_RD_CHAR: begin
                state_nx  = ST_RD_ATTR;
                vram_rd   = 1'b1;
                vram_addr = {addr_q, 1'b0};
            end
            ST_RD_ATTR: begin
                state_nx  = ST_RD_FONT;
                vram_rd   = 1'b1;
                vram_addr = {addr_q, 1'b0} + 15'd1;
            end
            ST_RD_FONT: begin
                state_nx  = ST_HOLD;
                font_addr = {char_q, row_q};
            end
            ST_HOLD: state_nx = ST_HOLD;
            default: state_nx = ST_IDLE;
        endcase
        if (divclk) begin
            state_nx = ST_RD_CHAR;
        end
    end

    // A period of exactly 4 clk lands divclk on the first HOLD cycle; forward the glyph.
    assign glyph_now = (state == ST_HOLD && font_pend) ? font_data : glyph_stg;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            row_q     <= '0;
            char_q    <= '0;
            attr_stg  <= '0;
            glyph_stg <= '0;
            font_pend <= 1'b0;
            tim_lat   <= '0;
            meta_sh   <= '0;
            shift_q   <= '0;
            frame_cnt <= '0;
            vsync_q   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (vsync && !vsync_q) begin
                frame_cnt <= frame_cnt + 5'd1;
            end
            font_pend <= (state == ST_RD_FONT) && !divclk;
            if (state == ST_RD_ATTR && !divclk) begin
                char_q <= vram_data;
            end
            if (state == ST_RD_FONT && !divclk) begin
                attr_stg <= vram_data;
            end
            glyph_stg <= glyph_now;
            if (divclk) begin
                addr_q          <= mem_addr;
                row_q           <= row_addr[2:0];
                tim_lat.hsync   <= hsync;
                tim_lat.vsync   <= vsync;
                tim_lat.de      <= display_enable;
                tim_lat.cursor  <= cursor;
                meta_sh.attr    <= attr_stg;
                meta_sh.tim     <= tim_lat;
                shift_q         <= CHAR_W'(glyph_now) << (CHAR_W - 8);
            end else begin
                shift_q <= shift_q << 1;
            end
        end
    end

    assign hsync_o = meta_sh.tim.hsync;
    assign vsync_o = meta_sh.tim.vsync;
    assign de_o    = meta_sh.tim.de;

    mda_attr_decode u_attr_decode (
        .attr      (meta_sh.attr),
        .glyph_bit (shift_q[CHAR_W-1]),
        .cursor    (meta_sh.tim.cursor),
        .blink     (frame_cnt[BLINK_BIT]),
        .blink_en  (blink_en),
        .de        (meta_sh.tim.de),
        .pixel     (pixel)
    );

endmodule

// File: tb/tb_mda_text_pixel_pipe.sv
// Scoreboard bench: cells are queued at divclk, a monitor checks the shifted pixels.
module tb_mda_text_pixel_pipe;

    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        divclk = 1'b0;
    logic [13:0] mem_addr = '0;
    logic [4:0]  row_addr = '0;
    logic        display_enable = 1'b0;
    logic        cursor = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        blink_en = 1'b0;
    logic [14:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_data = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [3:0]  pixel;
    logic        hsync_o, vsync_o, de_o;

    always #5 clk = ~clk;

    mda_text_pixel_pipe #(.BLINK_BIT(BLINK), .CHAR_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .divclk         (divclk),
        .mem_addr       (mem_addr),
        .row_addr       (row_addr),
        .display_enable (display_enable),
        .cursor         (cursor),
        .hsync          (hsync),
        .vsync          (vsync),
        .blink_en       (blink_en),
        .vram_addr      (vram_addr),
        .vram_rd        (vram_rd),
        .vram_data      (vram_data),
        .font_addr      (font_addr),
        .font_data      (font_data),
        .pixel          (pixel),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .de_o           (de_o)
    );

    logic [7:0] vram [0:32767];
    logic [7:0] font [0:2047];

    // Memories answer one clk after the address; unread VRAM cycles return noise.
    always @(posedge clk) begin : mem_model
        logic [14:0] a;
        logic        rd;
        logic [10:0] fa;
        a  = vram_addr;
        rd = vram_rd;
        fa = font_addr;
        #1;
        vram_data = rd ? vram[a] : 8'($urandom);
        font_data = font[fa];
    end

    typedef struct {
        logic [7:0] glyph;
        logic [7:0] attr;
        logic       cur;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   frames = 0;
    logic vs_seen = 1'b0;

    logic [13:0] p_addr;
    logic [4:0]  p_row;
    logic        p_cur, p_de, p_hs, p_vs;
    bit          p_valid, p_complete;
    logic [7:0]  stg_g, stg_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame count follows vsync rising edges as seen at each clock edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            frames  = 0;
            vs_seen = 1'b0;
        end else begin
            if (vsync && !vs_seen) frames++;
            vs_seen = vsync;
        end
        #1;
    endtask

    function automatic logic [3:0] ref_px(input exp_t e, input int idx);
        logic [3:0] fg, bg;
        int phase;
        if (!e.de) return 4'h0;
        phase = ((frames % 32) >> BLINK) & 1;
        fg = e.attr[3:0];
        bg = {1'b0, e.attr[6:4]} + ((e.attr[7] && !blink_en) ? 4'd8 : 4'd0);
        if (blink_en && e.attr[7] && phase == 0) fg = bg;
        if (e.cur) return fg;
        return e.glyph[7-idx] ? fg : bg;
    endfunction

    initial begin : monitor
        exp_t cur_e;
        int   idx;
        bit   have;
        have = 0;
        idx  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have = 0;
            end else begin
                if (have && idx < 8) begin
                    chk($sformatf("pixel[%0d]", idx), pixel, ref_px(cur_e, idx));
                    chk("de_o", de_o, cur_e.de);
                    chk("hsync_o", hsync_o, cur_e.hs);
                    chk("vsync_o", vsync_o, cur_e.vs);
                    idx++;
                end
                if (divclk) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        have = 0;
                        $display("FAIL sb_underflow: got empty queue want 1 entry at %0t", $time);
                    end else begin
                        cur_e = q.pop_front();
                        have  = 1;
                        idx   = 0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        divclk = 1'b0;
        tick();
        #3;
        chk("rst_vram_rd", vram_rd, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_font_addr", font_addr, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_de_o", de_o, 0);
        chk("rst_hsync_o", hsync_o, 0);
        chk("rst_vsync_o", vsync_o, 0);
        tick();
        reset = 1'b0;
        q.delete();
        p_valid = 0; p_complete = 0;
        p_addr = '0; p_row = '0;
        p_cur = 0; p_de = 0; p_hs = 0; p_vs = 0;
        stg_g = '0; stg_a = '0;
    endtask

    task automatic step(input logic [13:0] a, input logic [4:0] r, input logic c, input logic d,
                        input logic h, input logic v, input int p, input int abort);
        exp_t        e;
        logic [7:0]  ch;
        logic [14:0] base;
        tick();
        divclk = 1'b1;
        mem_addr = a; row_addr = r; cursor = c; display_enable = d; hsync = h; vsync = v;
        // The cell loaded now is whatever the previous fetch managed to stage.
        if (p_valid && p_complete) begin
            ch    = vram[{p_addr, 1'b0}];
            stg_g = font[{ch, p_row[2:0]}];
            stg_a = vram[{p_addr, 1'b1}];
        end
        e = '{glyph: stg_g, attr: stg_a, cur: p_cur, de: p_de, hs: p_hs, vs: p_vs};
        q.push_back(e);
        p_addr = a; p_row = r; p_cur = c; p_de = d; p_hs = h; p_vs = v;
        p_valid = 1; p_complete = (p >= 4);
        base = {a, 1'b0};
        ch = vram[base];
        for (int k = 1; k < p; k++) begin
            tick();
            divclk = 1'b0;
            mem_addr = 14'($urandom);
            row_addr = 5'($urandom);
            cursor = 1'($urandom);
            display_enable = 1'($urandom);
            hsync = 1'($urandom);
            #3;
            if (k <= 2) begin
                chk("vram_rd_on", vram_rd, 1);
                chk("vram_addr", vram_addr, base + 15'(k - 1));
            end else begin
                chk("vram_rd_off", vram_rd, 0);
            end
            if (k == 3) chk("font_addr", font_addr, {ch, r[2:0]});
            if (k == abort) begin
                do_reset();
                return;
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int p, ab;
        for (int i = 0; i < 32768; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
        do_reset();

        vram[15'h000A] = 8'h41;
        vram[15'h000B] = 8'h1F;
        font[11'h20B]  = 8'hF0;
        step(14'h0005, 5'd3, 0, 1, 1, 0, 8, -1);

        vram[15'h0020] = 8'h20;
        vram[15'h0021] = 8'h07;
        font[{8'h20, 3'd0}] = 8'h00;
        step(14'h0010, 5'd0, 1, 1, 0, 0, 8, -1);

        vram[15'h0022] = 8'h55;
        vram[15'h0023] = 8'h1E;
        font[{8'h55, 3'd0}] = 8'hFF;
        step(14'h0011, 5'd0, 0, 0, 0, 0, 8, -1);
        step(14'h3FFF, 5'd6, 0, 1, 0, 0, 8, -1);
        step(14'h0123, 5'd2, 0, 1, 0, 0, 8, 2);
        step(14'h0456, 5'd1, 0, 1, 0, 0, 8, -1);

        vram[15'h0200] = 8'h41;
        vram[15'h0201] = 8'h8F;
        font[{8'h41, 3'd1}] = 8'hF0;
        blink_en = 1'b1;
        for (int i = 0; i < 140; i++) step(14'h0100, 5'd1, 0, 1, 0, 1'(i % 2), 8, -1);
        blink_en = 1'b0;
        for (int i = 0; i < 4; i++) step(14'h0100, 5'd1, 0, 1, 0, 0, 8, -1);

        for (int i = 0; i < 250; i++) begin
            p  = ($urandom % 4 == 0) ? int'($urandom_range(2, 12)) : 8;
            ab = ($urandom % 40 == 0) ? int'($urandom_range(1, p - 1)) : -1;
            if ($urandom % 16 == 0) blink_en = 1'($urandom);
            step(14'($urandom), 5'($urandom), ($urandom % 8 == 0), ($urandom % 8 != 0),
                 1'($urandom), 1'($urandom), p, ab);
        end
        step(14'h0000, 5'd0, 0, 0, 0, 0, 8, -1);
        step(14'h0000, 5'd0, 0, 0, 0, 0, 8, -1);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
